// File: rtl/conv3x3_frame_sequencer_pkg.sv
// Shared defaults, window geometry, FSM encoding and index helper for the
// 3x3 convolution frame sequencer.
package conv3x3_frame_sequencer_pkg;

  localparam int unsigned DEF_DW    = 16;
  localparam int unsigned DEF_IMG_W = 7;
  localparam int unsigned DEF_IMG_H = 7;

  localparam int unsigned WIN     = 3;
  localparam int unsigned WIN_SZ  = WIN * WIN;
  localparam int unsigned NUM_OUT = (DEF_IMG_W - WIN + 1) * (DEF_IMG_H - WIN + 1);

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_LOAD_K,
    ST_LOAD_P,
    ST_CONV,
    ST_DRAIN
  } state_t;

  // Raster index of window element (i,j) for output position (r,c).
  function automatic int unsigned win_index(input int unsigned r,
                                            input int unsigned c,
                                            input int unsigned i,
                                            input int unsigned j,
                                            input int unsigned img_w);
    return (r + i) * img_w + c + j;
  endfunction

endpackage

// File: rtl/conv3x3_frame_sequencer_if.sv
// Input stream, output stream and MAC bus of the frame sequencer.
// master = sequencer side, slave = loader / MAC / result sink side.
interface conv3x3_frame_sequencer_if
  import conv3x3_frame_sequencer_pkg::*;
#(
  parameter int unsigned DW = DEF_DW
);

  logic                 in_valid;
  logic                 in_ready;
  logic [DW-1:0]        in_data;
  logic [WIN_SZ*DW-1:0] mac_core;
  logic [WIN_SZ*DW-1:0] mac_pix;
  logic [DW-1:0]        mac_result;
  logic                 out_valid;
  logic                 out_ready;
  logic [DW-1:0]        out_data;

  modport master (
    input  in_valid, in_data, mac_result, out_ready,
    output in_ready, mac_core, mac_pix, out_valid, out_data
  );

  modport slave (
    output in_valid, in_data, mac_result, out_ready,
    input  in_ready, mac_core, mac_pix, out_valid, out_data
  );

endinterface

// File: rtl/conv3x3_window_mux.sv
// Combinational selection of the 3x3 pixel window at output position (r,c)
// from the stored frame, packed row-major like the kernel bus.
module conv3x3_window_mux
  import conv3x3_frame_sequencer_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input  logic [2:0]                      r,
  input  logic [2:0]                      c,
  input  logic [IMG_W*IMG_H-1:0][DW-1:0]  frame,
  output logic [WIN_SZ*DW-1:0]            pix
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned AW   = $clog2(NPIX);

  logic [AW-1:0] idx;

  // Gather the nine window pixels in row-major order.
  always_comb begin
    pix = '0;
    idx = '0;
    for (int unsigned i = 0; i < WIN; i++) begin
      for (int unsigned j = 0; j < WIN; j++) begin
        idx = AW'(win_index(32'(r), 32'(c), i, j, IMG_W));
        pix[(WIN*i + j)*DW +: DW] = frame[idx];
      end
    end
  end

endmodule

// File: rtl/conv3x3_frame_sequencer.sv
// Loads a 3x3 kernel and a frame over a valid/ready stream, then walks every
// valid output position, presenting window and kernel to an external MAC and
// streaming the results out through a 1-deep output register.
module conv3x3_frame_sequencer
  import conv3x3_frame_sequencer_pkg::*;
#(
  parameter int unsigned DW    = DEF_DW,
  parameter int unsigned IMG_W = DEF_IMG_W,
  parameter int unsigned IMG_H = DEF_IMG_H
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        start,
  conv3x3_frame_sequencer_if.master   bus,
  output logic                        busy,
  output logic                        finish
);

  localparam int unsigned NPIX = IMG_W * IMG_H;
  localparam int unsigned AW   = $clog2(NPIX);
  localparam int unsigned KW   = $clog2(WIN_SZ);

  localparam logic [AW-1:0] K_LAST = AW'(WIN_SZ - 1);
  localparam logic [AW-1:0] P_LAST = AW'(NPIX - 1);
  localparam logic [2:0]    C_LAST = 3'(IMG_W - WIN);
  localparam logic [2:0]    R_LAST = 3'(IMG_H - WIN);

  state_t                   state;
  logic [AW-1:0]            load_idx;
  logic [2:0]               r;
  logic [2:0]               c;
  logic                     in_ready_q;
  logic                     out_valid_q;
  logic [DW-1:0]            out_data_q;

  logic [WIN_SZ-1:0][DW-1:0] kern;
  logic [NPIX-1:0][DW-1:0]   frame;
  logic [WIN_SZ*DW-1:0]      win_pix;

  logic in_fire;
  logic out_fire;
  logic advance;

  assign in_fire  = bus.in_valid && in_ready_q;
  assign out_fire = out_valid_q && bus.out_ready;
  // Capture whenever the output register is free or is being emptied now.
  assign advance  = (state == ST_CONV) && (!out_valid_q || bus.out_ready);

  // Kernel and frame storage; contents are don't-care after reset.
  always_ff @(posedge clk) begin
    if (in_fire) begin
      if (state == ST_LOAD_K) begin
        kern[load_idx[KW-1:0]] <= bus.in_data;
      end else begin
        frame[load_idx] <= bus.in_data;
      end
    end
  end

  conv3x3_window_mux #(
    .DW    (DW),
    .IMG_W (IMG_W),
    .IMG_H (IMG_H)
  ) u_window_mux (
    .r     (r),
    .c     (c),
    .frame (frame),
    .pix   (win_pix)
  );

  assign bus.mac_core  = (state == ST_CONV) ? kern    : '0;
  assign bus.mac_pix   = (state == ST_CONV) ? win_pix : '0;
  assign bus.in_ready  = in_ready_q;
  assign bus.out_valid = out_valid_q;
  assign bus.out_data  = out_data_q;

  // Job sequencing FSM with registered handshake and status outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state       <= ST_IDLE;
      load_idx    <= '0;
      r           <= '0;
      c           <= '0;
      in_ready_q  <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      busy        <= 1'b0;
      finish      <= 1'b0;
    end else begin
      finish <= 1'b0;
      case (state)
        ST_IDLE: begin
          if (start) begin
            state      <= ST_LOAD_K;
            load_idx   <= '0;
            r          <= '0;
            c          <= '0;
            in_ready_q <= 1'b1;
            busy       <= 1'b1;
          end
        end

        ST_LOAD_K: begin
          if (in_fire) begin
            if (load_idx == K_LAST) begin
              load_idx <= '0;
              state    <= ST_LOAD_P;
            end else begin
              load_idx <= load_idx + AW'(1);
            end
          end
        end

        ST_LOAD_P: begin
          if (in_fire) begin
            if (load_idx == P_LAST) begin
              load_idx   <= '0;
              in_ready_q <= 1'b0;
              r          <= '0;
              c          <= '0;
              state      <= ST_CONV;
            end else begin
              load_idx <= load_idx + AW'(1);
            end
          end
        end

        ST_CONV: begin
          if (advance) begin
            out_data_q  <= bus.mac_result;
            out_valid_q <= 1'b1;
            if (c == C_LAST) begin
              c <= '0;
              if (r == R_LAST) begin
                r     <= '0;
                state <= ST_DRAIN;
              end else begin
                r <= r + 3'd1;
              end
            end else begin
              c <= c + 3'd1;
            end
          end
        end

        ST_DRAIN: begin
          if (out_fire) begin
            out_valid_q <= 1'b0;
            finish      <= 1'b1;
            busy        <= 1'b0;
            state       <= ST_IDLE;
          end
        end

        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_conv3x3_frame_sequencer.sv
// Directed bench for conv3x3_frame_sequencer with a Q4.12 3x3 MAC model.
module tb_conv3x3_frame_sequencer;
  import conv3x3_frame_sequencer_pkg::*;

  logic clk = 1'b0;
  logic rst_n;
  logic start;
  logic busy;
  logic finish;

  int total = 0;
  int bad   = 0;

  logic [15:0]  kern_v [9];
  logic [143:0] kexp;
  logic [31:0]  acc;

  conv3x3_frame_sequencer_if #(.DW(16)) bus ();

  conv3x3_frame_sequencer #(
    .DW    (16),
    .IMG_W (7),
    .IMG_H (7)
  ) dut (
    .clk    (clk),
    .rst_n  (rst_n),
    .start  (start),
    .bus    (bus),
    .busy   (busy),
    .finish (finish)
  );

  always #5 clk = ~clk;

  // External 16-bit fixed-point MAC: sum(k*p) >> 12.
  always_comb begin
    acc = '0;
    for (int unsigned k = 0; k < 9; k++) begin
      acc = acc + 32'(bus.mac_core[k*16 +: 16]) * 32'(bus.mac_pix[k*16 +: 16]);
    end
    bus.mac_result = acc[27:12];
  end

  task automatic check(input string tag, input logic [159:0] obs, input logic [159:0] exp);
    total++;
    assert (obs === exp)
      else begin
        bad++;
        $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_kernel(input logic [15:0] center);
    for (int k = 0; k < 9; k++) kern_v[k] = 16'h0000;
    kern_v[4] = center;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
    check("start_busy", busy, 1);
    check("start_in_ready", bus.in_ready, 1);
  endtask

  // Send 9 kernel words then pixels p[n]=n; optional valid gaps and start poke.
  task automatic load_job(input bit gaps, input bit poke_start);
    int   sent = 0;
    int   cyc  = 0;
    logic rdy;
    while (sent < 58 && cyc < 400) begin
      bus.in_valid = (gaps && (cyc % 3) == 1) ? 1'b0 : 1'b1;
      bus.in_data  = (sent < 9) ? kern_v[sent] : 16'(sent - 9);
      start        = (poke_start && sent == 30) ? 1'b1 : 1'b0;
      rdy          = bus.in_ready;
      tick();
      cyc++;
      if (bus.in_valid && rdy) sent++;
    end
    bus.in_valid = 1'b0;
    start        = 1'b0;
    check("load_words", sent, 58);
    check("conv_in_ready", bus.in_ready, 0);
    check("conv_out_valid0", bus.out_valid, 0);
    check("conv_busy", busy, 1);
    for (int k = 0; k < 9; k++) kexp[k*16 +: 16] = kern_v[k];
    check("mac_core", bus.mac_core, kexp);
    check("mac_pix00", bus.mac_pix,
          {16'd16, 16'd15, 16'd14, 16'd9, 16'd8, 16'd7, 16'd2, 16'd1, 16'd0});
  endtask

  // Collect results; pattern 0 = ready high, 1 = ready cycles 1,0,0,1.
  task automatic run_results(input int pattern, input int scale, input int stop_after,
                             input bit poke_start);
    int          got = 0;
    int          cyc = 0;
    bit          stalled = 1'b0;
    logic [15:0] held = '0;
    logic [15:0] expv;
    while (got < stop_after && cyc < 300) begin
      bus.out_ready = (pattern == 0) ? 1'b1 : ((cyc % 4) == 0 || (cyc % 4) == 3);
      start         = (poke_start && got == 5 && cyc < 8) ? 1'b1 : 1'b0;
      if (cyc == 1) check("first_valid", bus.out_valid, 1);
      if (stalled) begin
        check("stall_valid", bus.out_valid, 1);
        check("stall_hold", bus.out_data, held);
      end
      check("no_early_finish", finish, 0);
      if (bus.out_valid && bus.out_ready) begin
        expv = 16'(scale * (8 + 7 * (got / 5) + (got % 5)));
        check($sformatf("res%0d", got), bus.out_data, expv);
        got++;
      end
      stalled = bus.out_valid && !bus.out_ready;
      held    = bus.out_data;
      tick();
      cyc++;
    end
    start = 1'b0;
    check("res_count", got, stop_after);
    if (stop_after == NUM_OUT) begin
      check("finish_pulse", finish, 1);
      check("finish_busy", busy, 0);
      check("finish_out_valid", bus.out_valid, 0);
      check("finish_in_ready", bus.in_ready, 0);
      tick();
      check("finish_once", finish, 0);
    end
  endtask

  initial begin
    rst_n         = 1'b0;
    start         = 1'b0;
    bus.in_valid  = 1'b0;
    bus.in_data   = '0;
    bus.out_ready = 1'b0;
    set_kernel(16'h1000);
    tick();
    tick();
    check("rst_in_ready", bus.in_ready, 0);
    check("rst_out_valid", bus.out_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_finish", finish, 0);
    check("rst_out_data", bus.out_data, 0);
    check("rst_mac_core", bus.mac_core, 0);
    check("rst_mac_pix", bus.mac_pix, 0);
    rst_n = 1'b1;
    tick();
    check("idle_in_ready", bus.in_ready, 0);

    // Identity kernel, ready always high.
    pulse_start();
    load_job(1'b0, 1'b0);
    run_results(0, 1, NUM_OUT, 1'b0);

    // Same job with backpressure.
    pulse_start();
    load_job(1'b0, 1'b0);
    run_results(1, 1, NUM_OUT, 1'b0);
    bus.out_ready = 1'b0;

    // Gaps in the input stream.
    pulse_start();
    load_job(1'b1, 1'b0);
    run_results(0, 1, NUM_OUT, 1'b0);

    // start poked during LOAD_P and CONV must be ignored.
    pulse_start();
    load_job(1'b0, 1'b1);
    run_results(0, 1, NUM_OUT, 1'b1);

    // New kernel: doubled outputs.
    set_kernel(16'h2000);
    pulse_start();
    load_job(1'b0, 1'b0);
    run_results(0, 2, NUM_OUT, 1'b0);

    // Reset after 10 results in CONV.
    set_kernel(16'h1000);
    pulse_start();
    load_job(1'b0, 1'b0);
    run_results(0, 1, 10, 1'b0);
    rst_n = 1'b0;
    tick();
    check("midrst_out_valid", bus.out_valid, 0);
    check("midrst_busy", busy, 0);
    check("midrst_in_ready", bus.in_ready, 0);
    check("midrst_finish", finish, 0);
    rst_n = 1'b1;
    tick();
    check("midrst_no_finish", finish, 0);
    check("midrst_idle_busy", busy, 0);

    // Full job after reset, then a back-to-back job started the cycle after finish.
    pulse_start();
    load_job(1'b0, 1'b0);
    run_results(0, 1, NUM_OUT, 1'b0);
    pulse_start();
    load_job(1'b0, 1'b0);
    run_results(0, 1, NUM_OUT, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
